// File: rtl/uart_rx_deframer.sv
// 8N1 UART receive deframer with ready/valid byte output and sticky frame/overrun flags.
// Optional macro UART_RX_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
//
// state   | meaning
// S_ARM   | wait for CPB consecutive idle-high cycles before trusting the line
// S_IDLE  | line idle, waiting for a start edge
// S_START | inside start bit, re-checked at the sample point
// S_DATA  | shifting in 8 data bits, LSB first
// S_STOP  | stop bit, resolved at the sample point
module uart_rx_deframer #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_serial_in,
  output logic [7:0] o_data_out,
  output logic       o_data_out_valid,
  input  logic       i_data_out_ready,
  output logic       o_rx_busy,
  output logic       o_frame_error,
  output logic       o_overrun,
  input  logic       i_err_clear
);

  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_ZERO   = '0;
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(CPB / 2);

  typedef enum logic [2:0] {S_ARM, S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit_idx, w_bit_idx_nxt;
  logic [7:0]  r_shreg, w_shreg_nxt;
  logic [7:0]  r_data_out;
  logic        r_valid, r_frame_error, r_overrun;
  logic        w_rx, w_sample, w_last, w_byte_done, w_frame_bad, w_can_load;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_serial_in};
  end
  assign w_rx = r_sync[1];
`else
  assign w_rx = i_serial_in;
`endif

  assign w_sample   = (r_cnt == CNT_SAMPLE);
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_can_load = !r_valid || i_data_out_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shreg_nxt   = r_shreg;
    w_byte_done   = 1'b0;
    w_frame_bad   = 1'b0;
    case (r_state)
      S_ARM: begin
        if (!w_rx) begin
          w_cnt_nxt = CNT_ZERO;
        end else if (w_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        // the detecting cycle is cnt=0 of the start bit
        if (!w_rx) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      S_START: begin
        if (w_sample && w_rx) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end else if (w_last) begin
          w_state_nxt   = S_DATA;
          w_cnt_nxt     = CNT_ZERO;
          w_bit_idx_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_sample) w_shreg_nxt = {w_rx, r_shreg[7:1]};
        if (w_last) begin
          w_cnt_nxt     = CNT_ZERO;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          w_cnt_nxt = CNT_ZERO;
          if (w_rx) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = S_ARM;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_ARM;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_ARM;
      r_cnt         <= CNT_ZERO;
      r_bit_idx     <= 3'd0;
      r_shreg       <= 8'h00;
      r_data_out    <= 8'h00;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      if (w_byte_done && w_can_load) begin
        r_data_out <= r_shreg;
        r_valid    <= 1'b1;
      end else if (r_valid && i_data_out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_byte_done && !w_can_load) r_overrun <= 1'b1;
      else if (i_err_clear)           r_overrun <= 1'b0;
      if (w_frame_bad)                r_frame_error <= 1'b1;
      else if (i_err_clear)           r_frame_error <= 1'b0;
    end
  end

  assign o_data_out       = r_data_out;
  assign o_data_out_valid = r_valid;
  assign o_frame_error    = r_frame_error;
  assign o_overrun        = r_overrun;
  assign o_rx_busy        = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP) ||
                            ((r_state == S_IDLE) && !w_rx);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CPB=5; honours UART_RX_SYNC_EN for the expected latency.
module tb_uart_rx_deframer;

  localparam int CPB = 5;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = 9 * CPB + CPB / 2 + 1 + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst, rx, ready, err_clr;
  logic [7:0] dout;
  logic       valid, busy, fe, ovr;

  always #5 clk = ~clk;

  uart_rx_deframer #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000)) dut (
    .i_clk(clk), .i_rst(rst), .i_serial_in(rx),
    .o_data_out(dout), .o_data_out_valid(valid), .i_data_out_ready(ready),
    .o_rx_busy(busy), .o_frame_error(fe), .o_overrun(ovr), .i_err_clear(err_clr)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int         vcyc[$];
  logic [7:0] vdat[$];
  int         busy_n = 0;
  always @(negedge clk) begin
    #2;
    if (valid === 1'b1) begin
      vcyc.push_back(cyc);
      vdat.push_back(dout);
    end
    if (busy === 1'b1) busy_n++;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int first_lat(input int t);
    return (vcyc.size() > 0) ? vcyc[0] - t : -1;
  endfunction

  function automatic logic [7:0] first_dat();
    return (vdat.size() > 0) ? vdat[0] : 8'hxx;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    rx = 1'b1;
    vcyc.delete();
    vdat.delete();
    busy_n = 0;
  endtask

  // rst_at / rdy_at / clr_at: frame-relative cycle for a 1-cycle pulse, -1 for none
  task automatic send(input logic [7:0] b, input logic stopb, input int rst_at,
                      input int rdy_at, input int clr_at, output int t);
    logic [9:0] fr;
    int i;
    fr = {stopb, b, 1'b0};
    t = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        i = k * CPB + j;
        @(negedge clk);
        if (i == 0) t = cyc;
        rx      = fr[0];
        rst     = (i == rst_at) ? 1'b0 : 1'b1;
        err_clr = (i == clr_at);
        if (rdy_at >= 0) begin
          if (i == rdy_at) ready = 1'b1;
          else if (i == rdy_at + 1) ready = 1'b0;
        end
      end
      fr = fr >> 1;
    end
    if (rdy_at >= 0 || clr_at >= 0) begin
      @(negedge clk);
      rx      = 1'b1;
      ready   = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stopb;
    int         exp_cnt;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int t, t2;
    vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 1'b0};
    vecs[1] = '{8'hff, 1'b1, 1, 8'hff, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1, 8'h80, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 1'b0};
    vecs[4] = '{8'h5a, 1'b0, 0, 8'h00, 1'b1};
    vecs[5] = '{8'hc3, 1'b1, 1, 8'hc3, 1'b0};

    rst = 1'b0; rx = 1'b1; ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_data", 32'(dout), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fe", 32'(fe), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);

    // scenario 1: release, 5 idle cycles, one byte with ready held high
    @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    idle(4);
    vcyc.delete(); vdat.delete();
    send(8'h61, 1'b1, -1, -1, -1, t);
    idle(3);
    #3;
    chk("s1_valid_cycles", vcyc.size(), 1);
    chk("s1_latency", first_lat(t), LAT);
    chk("s1_data", 32'(first_dat()), 32'h61);
    chk("s1_fe", 32'(fe), 32'h0);
    chk("s1_ovr", 32'(ovr), 32'h0);

    // scenario 2: back-to-back with ready low -> overrun
    ready = 1'b0;
    clear_mon();
    send(8'h31, 1'b1, -1, -1, -1, t);
    send(8'h35, 1'b1, -1, -1, -1, t2);
    idle(3);
    #3;
    chk("s2_latency", first_lat(t), LAT);
    chk("s2_data", 32'(dout), 32'h31);
    chk("s2_valid", 32'(valid), 32'h1);
    chk("s2_ovr", 32'(ovr), 32'h1);
    chk("s2_fe", 32'(fe), 32'h0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #3;
    chk("s2_ovr_cleared", 32'(ovr), 32'h0);
    chk("s2_valid_kept", 32'(valid), 32'h1);
    @(negedge clk); ready = 1'b1;
    @(negedge clk);
    #3;
    chk("s2_valid_drop", 32'(valid), 32'h0);
    chk("s2_data_hold", 32'(dout), 32'h31);

    // scenario 3: 2-cycle glitch is a false start
    clear_mon();
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle(6);
    #3;
    chk("s3_busy_cycles", busy_n, 3);
    chk("s3_no_valid", vcyc.size(), 0);
    clear_mon();
    send(8'h3e, 1'b1, -1, -1, -1, t);
    idle(3);
    #3;
    chk("s3_latency", first_lat(t), LAT);
    chk("s3_data", 32'(first_dat()), 32'h3e);

    // scenario 4: stop bit 0, then exactly 5 idle cycles before the next frame
    clear_mon();
    send(8'h55, 1'b0, -1, -1, -1, t);
    idle(5);
    #3;
    chk("s4_fe", 32'(fe), 32'h1);
    chk("s4_no_valid", vcyc.size(), 0);
    send(8'h0d, 1'b1, -1, -1, -1, t2);
    idle(3);
    #3;
    chk("s4_latency", first_lat(t2), LAT);
    chk("s4_data", 32'(first_dat()), 32'h0d);
    chk("s4_fe_sticky", 32'(fe), 32'h1);

    // scenario 5: reset mid-frame (past bit 3); ready low so 8'h20 stays pending
    ready = 1'b0;
    clear_mon();
    send(8'ha5, 1'b1, 7 * CPB, -1, -1, t);
    #3;
    chk("s5_data_reset", 32'(dout), 32'h0);
    chk("s5_valid_reset", 32'(valid), 32'h0);
    chk("s5_fe_reset", 32'(fe), 32'h0);
    chk("s5_no_valid", vcyc.size(), 0);
    idle(2);
    send(8'h20, 1'b1, -1, -1, -1, t2);
    idle(3);
    #3;
    chk("s5_latency", first_lat(t2), LAT);
    chk("s5_data", 32'(dout), 32'h20);
    chk("s5_valid", 32'(valid), 32'h1);

    // scenario 6: ready pulses on the exact accept edge of the next byte
    send(8'h7a, 1'b1, -1, LAT - 1, -1, t);
    idle(3);
    #3;
    chk("s6_data", 32'(dout), 32'h7a);
    chk("s6_valid", 32'(valid), 32'h1);
    chk("s6_ovr", 32'(ovr), 32'h0);

    // overrun set and err_clear on the same edge: set wins
    send(8'h11, 1'b1, -1, -1, LAT - 1, t);
    idle(3);
    #3;
    chk("s7_ovr_set_wins", 32'(ovr), 32'h1);
    chk("s7_data_kept", 32'(dout), 32'h7a);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #3;
    chk("s7_ovr_cleared", 32'(ovr), 32'h0);

    ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send(vecs[v].b, vecs[v].stopb, -1, -1, -1, t);
      idle(CPB + 2);
      #3;
      chk($sformatf("vec%0d_count", v), vcyc.size(), vecs[v].exp_cnt);
      if (vecs[v].exp_cnt > 0) begin
        chk($sformatf("vec%0d_latency", v), first_lat(t), LAT);
        chk($sformatf("vec%0d_data", v), 32'(first_dat()), 32'(vecs[v].exp_data));
      end
      chk($sformatf("vec%0d_fe", v), 32'(fe), 32'(vecs[v].exp_fe));
      chk($sformatf("vec%0d_ovr", v), 32'(ovr), 32'h0);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
    end
    #3;
    chk("final_fe_cleared", 32'(fe), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
